// File: rtl/mem_multicycle_responder_if.sv
// Request/response bundle between the miss arbiter and the memory responder.
// Handshake: a request is taken on every rising edge where enable = 1 (no ready,
// never stalled); a read result is consumed in any cycle where data_valid = 1.
interface mem_multicycle_responder_if;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_valid;
  logic [3:0]  pending;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, pending
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, pending
  );
endinterface

// File: rtl/mem_multicycle_responder.sv
// Pipelined main-memory responder. Reads sample the array when they are
// accepted and ride a LATENCY-deep shift pipeline to data_out. Writes commit
// at the acceptance edge. The array itself is never reset.
module mem_multicycle_responder #(
  parameter int LATENCY   = 4,
  parameter int MEM_WORDS = 32768
) (
  input  logic                        clk,
  input  logic                        rst,
  mem_multicycle_responder_if.slave   bus
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [15:0]        mem [MEM_WORDS];
  logic [AW-1:0]      idx;
  logic               rd_accept;
  logic               wr_accept;
  logic [15:0]        rd_word;
  logic [LATENCY-1:0] pipe_valid;
  logic [15:0]        pipe_data [LATENCY];
  logic [3:0]         pending_q;

  // Word index drops the byte bit; upper bits past the array size are truncated.
  assign idx       = bus.addr[AW:1];
  assign rd_accept = bus.enable & ~bus.wr;
  assign wr_accept = bus.enable & bus.wr;
  assign rd_word   = mem[idx];

  // Array write port; gated by rst so requests are ignored while in reset.
  always_ff @(posedge clk) begin
    if (rst && wr_accept) begin
      mem[idx] <= bus.data_in;
    end
  end

  // Read pipeline: stage 0 captures the word, then everything shifts one stage
  // per cycle. Data is zeroed for bubbles so the last stage drives 0 when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= rd_accept;
      pipe_data[0]  <= rd_accept ? rd_word : 16'h0000;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  // Outstanding-read counter: +1 on read accept, -1 when a result leaves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= 4'd0;
    end else begin
      pending_q <= pending_q + {3'b000, rd_accept} - {3'b000, pipe_valid[LATENCY-1]};
    end
  end

  assign bus.data_out   = pipe_data[LATENCY-1];
  assign bus.data_valid = pipe_valid[LATENCY-1];
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_mem_multicycle_responder.sv
// Bench for mem_multicycle_responder: one instance at LATENCY = 4 and one at
// LATENCY = 1. A word-addressed reference memory predicts read data; each
// accepted read pushes {data, due cycle} and per-instance monitors compare.
module tb_mem_multicycle_responder;
  localparam int LAT0      = 4;
  localparam int LAT1      = 1;
  localparam int MEM_WORDS = 32768;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  mem_multicycle_responder_if bus0 ();
  mem_multicycle_responder_if bus1 ();

  mem_multicycle_responder #(.LATENCY(LAT0), .MEM_WORDS(MEM_WORDS)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  mem_multicycle_responder #(.LATENCY(LAT1), .MEM_WORDS(MEM_WORDS)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [15:0] mem0 [int];
  logic [15:0] mem1 [int];
  logic [15:0] exp0_q [$];
  int          due0_q [$];
  logic [15:0] exp1_q [$];
  int          due1_q [$];
  int          checks = 0;
  int          errors = 0;
  int          peak0  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; presents one request to the selected
  // instance for one cycle and updates the model at the acceptance edge.
  task automatic drive(input int sel, input logic en, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
    int n;
    int wi;
    bus0.enable  = (sel == 0) ? en : 1'b0;
    bus0.wr      = w;
    bus0.addr    = a;
    bus0.data_in = d;
    bus1.enable  = (sel == 1) ? en : 1'b0;
    bus1.wr      = w;
    bus1.addr    = a;
    bus1.data_in = d;
    n  = cyc;
    wi = (int'(a) >> 1) % MEM_WORDS;
    @(posedge clk);
    #1;
    if (en && rst) begin
      if (w) begin
        if (sel == 0) mem0[wi] = d;
        else          mem1[wi] = d;
      end else if (sel == 0) begin
        exp0_q.push_back(mem0[wi]);
        due0_q.push_back(n + LAT0);
      end else begin
        exp1_q.push_back(mem1[wi]);
        due1_q.push_back(n + LAT1);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic exp_v;
    if (!rst) begin
      check("rst_valid0", 32'(bus0.data_valid), 32'd0);
      check("rst_pending0", 32'(bus0.pending), 32'd0);
    end else begin
      if (int'(bus0.pending) > peak0) peak0 = int'(bus0.pending);
      check("pending0", 32'(bus0.pending), 32'(exp0_q.size()));
      exp_v = (due0_q.size() != 0) && (due0_q[0] == cyc);
      check("valid0", 32'(bus0.data_valid), 32'(exp_v));
      if (exp_v) begin
        check("data0", 32'(bus0.data_out), 32'(exp0_q[0]));
        void'(exp0_q.pop_front());
        void'(due0_q.pop_front());
      end else begin
        check("idle_data0", 32'(bus0.data_out), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    logic exp_v;
    if (rst) begin
      check("pending1", 32'(bus1.pending), 32'(exp1_q.size()));
      exp_v = (due1_q.size() != 0) && (due1_q[0] == cyc);
      check("valid1", 32'(bus1.data_valid), 32'(exp_v));
      if (exp_v) begin
        check("data1", 32'(bus1.data_out), 32'(exp1_q[0]));
        void'(exp1_q.pop_front());
        void'(due1_q.pop_front());
      end else begin
        check("idle_data1", 32'(bus1.data_out), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus0.enable = 1'b0; bus0.wr = 1'b0; bus0.addr = '0; bus0.data_in = '0;
    bus1.enable = 1'b0; bus1.wr = 1'b0; bus1.addr = '0; bus1.data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(bus0.data_valid), 32'd0);
    check("reset_data", 32'(bus0.data_out), 32'd0);
    #2 rst = 1'b1;

    // Preload words 0..63 with random data.
    for (int i = 0; i < 64; i++) drive(0, 1'b1, 1'b1, 16'(i * 2), 16'($urandom));

    // Single read of BEEF.
    drive(0, 1'b1, 1'b1, 16'h0100, 16'hBEEF);
    idle(2);
    drive(0, 1'b1, 1'b0, 16'h0100, 16'h0000);
    idle(6);

    // Eight-word block fill, back to back.
    for (int i = 0; i < 8; i++) drive(0, 1'b1, 1'b1, 16'(16'h0100 + 2 * i), 16'(16'h1000 + i));
    peak0 = 0;
    for (int i = 0; i < 8; i++) drive(0, 1'b1, 1'b0, 16'(16'h0100 + 2 * i), 16'h0000);
    idle(6);
    check("block_peak_pending", 32'(peak0), 32'(LAT0));

    // Write then immediate read.
    drive(0, 1'b1, 1'b1, 16'h0200, 16'hA5A5);
    drive(0, 1'b1, 1'b0, 16'h0200, 16'h0000);
    idle(6);

    // Write landing while a read of the same word is in flight.
    drive(0, 1'b1, 1'b1, 16'h0300, 16'h1111);
    idle(1);
    drive(0, 1'b1, 1'b0, 16'h0300, 16'h0000);
    drive(0, 1'b1, 1'b1, 16'h0300, 16'h2222);
    drive(0, 1'b1, 1'b0, 16'h0300, 16'h0000);
    idle(6);

    // Disabled bus must not write.
    drive(0, 1'b1, 1'b1, 16'h0400, 16'h0C0C);
    for (int i = 0; i < 10; i++) drive(0, 1'b0, 1'b1, 16'h0400, 16'hFFFF);
    drive(0, 1'b1, 1'b0, 16'h0400, 16'h0000);
    idle(6);

    // addr[0] is ignored.
    drive(0, 1'b1, 1'b1, 16'h0501, 16'h5A5A);
    drive(0, 1'b1, 1'b0, 16'h0500, 16'h0000);
    idle(6);

    // Randomised traffic over the preloaded words.
    for (int i = 0; i < 400; i++) begin
      drive(0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            16'($urandom_range(0, 63) * 2 + $urandom_range(0, 1)), 16'($urandom));
    end
    idle(6);

    // Mid-run reset with three reads in flight.
    drive(0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    drive(0, 1'b1, 1'b0, 16'h0002, 16'h0000);
    drive(0, 1'b1, 1'b0, 16'h0004, 16'h0000);
    bus0.enable = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus0.data_valid), 32'd0);
    check("async_rst_pending", 32'(bus0.pending), 32'd0);
    check("async_rst_data", 32'(bus0.data_out), 32'd0);
    exp0_q.delete(); due0_q.delete();
    exp1_q.delete(); due1_q.delete();
    drive(0, 1'b1, 1'b1, 16'h0000, 16'hDEAD);
    drive(0, 1'b1, 1'b1, 16'h0002, 16'hDEAD);
    #2 rst = 1'b1;
    // Array survives reset; writes during reset were ignored.
    drive(0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    drive(0, 1'b1, 1'b0, 16'h0002, 16'h0000);
    idle(8);

    // LATENCY = 1 instance.
    drive(1, 1'b1, 1'b1, 16'h0010, 16'($urandom));
    drive(1, 1'b1, 1'b1, 16'h0012, 16'($urandom));
    drive(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(2);
    drive(1, 1'b1, 1'b0, 16'h0012, 16'h0000);
    drive(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    drive(1, 1'b1, 1'b1, 16'h0010, 16'h7777);
    drive(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    for (int i = 0; i < 40; i++) begin
      drive(1, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            16'(16'h0010 + 2 * $urandom_range(0, 1)), 16'($urandom));
    end
    idle(8);

    check("drain0", 32'(exp0_q.size()), 32'd0);
    check("drain1", 32'(exp1_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
